point_rr_arbiter: RTL and testbench
===================================

Name: point_rr_arbiter

Overview:
- Shares one downstream t_point consumer between two point requesters, A and B.
- Each requester presents a t_point (x, y, each 8-bit unsigned) under a valid/ready handshake.
- The block grants round-robin, registers the winning point into a single output slot tagged with its source, and keeps saturating per-source grant counters for debug/performance readout.
- It sits between the point-update stages and the shared point sink (display/CSV logger).

Parameters:
COUNT_W, 16, width of each per-source grant counter (must be >= 2)

Ports:
clk  input  1  system clock; all logic on posedge clk
rst  input  1  reset, synchronous, active-high
point_i_A  input  16 (t_point)  requester A point
valid_i_A  input  1  requester A offers point_i_A
ready_i_A  output  1  A's point accepted this cycle
point_i_B  input  16 (t_point)  requester B point
valid_i_B  input  1  requester B offers point_i_B
ready_i_B  output  1  B's point accepted this cycle
point_o  output  16 (t_point)  registered granted point
src_o  output  1  source of point_o: 0 = A, 1 = B
valid_o  output  1  point_o/src_o hold a pending point
ready_o  input  1  downstream accepts point_o this cycle
cnt_A  output  COUNT_W  number of grants to A, saturating
cnt_B  output  COUNT_W  number of grants to B, saturating

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values: valid_o=0, point_o='{x:0,y:0}, src_o=0, cnt_A=0, cnt_B=0, internal last-grant pointer last=B. ready_i_A/ready_i_B are 0 while rst=1.
- Output slot has two states:
  - EMPTY: valid_o=0.
  - FULL: valid_o=1.
- The slot is free in a cycle when EMPTY, or when FULL and ready_o=1 (pass-through drain and refill in the same cycle).
- Arbitration (combinational, only when the slot is free):
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the source != last.
  - Neither valid -> no grant.
- ready_i_X = 1 only for the granted source in that cycle; at most one ready_i is high per cycle.
- ready_i_X is combinational from valid_i_*, valid_o, ready_o and last. There is no path from ready_i back to valid_i.
- On a grant (posedge), all of the following update together:
  - point_o <= granted point; src_o <= granted id; valid_o <= 1; last <= granted id.
  - Granted counter increments by 1, saturating at 2^COUNT_W-1; it never wraps.
- Slot free, no grant, and FULL&&ready_o: valid_o <= 0. point_o/src_o hold their last values (don't-care while valid_o=0).
- FULL and ready_o=0: point_o, src_o, valid_o are held stable, both ready_i=0, and last is unchanged.
- Latency: accepted point visible on point_o one cycle after its handshake. Sustained throughput is 1 point/cycle when ready_o=1.
- Fairness: with both valid continuously and ready_o=1, grants alternate A,B,A,B... The first grant after reset goes to A.
- The block does not modify point data; x/y pass bit-exact.
- rst asserted mid-operation: a pending output point is discarded (valid_o=0 next cycle), counters clear, last returns to B, and no handshake completes in the reset cycle.
- Requesters must hold point_i_X stable while valid_i_X=1 and ready_i_X=0. The block does not check this.

Test Plan:
- Reset then single request: rst for 4 cycles, then A valid with '{x:8'h12,y:8'h34} for one cycle, ready_o=1 -> ready_i_A=1 that cycle; next cycle point_o='{12,34}, src_o=0, valid_o=1; cnt_A=1, cnt_B=0.
- Contention round-robin: both A ('{01,01}') and B ('{ff,ff}') valid continuously, ready_o=1 for 6 cycles -> grants A,B,A,B,A,B; src_o sequence 0,1,0,1,0,1; cnt_A=3, cnt_B=3.
- Backpressure: slot FULL with B's '{fe,fe}', ready_o=0 for 3 cycles while A valid -> point_o/src_o/valid_o constant, ready_i_A=0; on ready_o=1, A is granted in that same cycle and point_o becomes A's point the next cycle with no bubble.
- Counter saturation: COUNT_W=2, A alone valid for 5 grants -> cnt_A goes 1,2,3,3,3 and never wraps to 0.
- Reset mid-operation: FULL with A point, ready_o=0, assert rst one cycle -> next cycle valid_o=0, cnt_A=cnt_B=0; after release with both valid, first grant goes to A.
- Idle drain: FULL, no valid inputs, ready_o=1 -> valid_o=0 next cycle; cnt_A/cnt_B unchanged.

Source files
------------

// File: rtl/point_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single registered t_point slot,
// with saturating per-source grant counters for debug/performance readout.

package point_pkg;
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } t_point;
endpackage

// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module point_sat_cnt #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [COUNT_W-1:0] cnt
);
  // count grants, holding at the maximum value
  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (inc && (~&cnt))    cnt <= cnt + 1'b1;
  end
endmodule

module point_rr_arbiter #(
  parameter int COUNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  point_pkg::t_point      point_i_A,
  input  logic                   valid_i_A,
  output logic                   ready_i_A,
  input  point_pkg::t_point      point_i_B,
  input  logic                   valid_i_B,
  output logic                   ready_i_B,
  output point_pkg::t_point      point_o,
  output logic                   src_o,
  output logic                   valid_o,
  input  logic                   ready_o,
  output logic [COUNT_W-1:0]     cnt_A,
  output logic [COUNT_W-1:0]     cnt_B
);
  import point_pkg::*;

  localparam int NUM_SRC = 2;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

  slot_e  state, state_nx;
  logic   last;
  logic   free;
  logic   gnt_vld;
  logic   gnt_id;
  t_point gnt_point;
  logic [NUM_SRC-1:0]              req;
  logic [NUM_SRC-1:0]              inc;
  logic [NUM_SRC-1:0][COUNT_W-1:0] cnt;

  assign req  = {valid_i_B, valid_i_A};
  // The slot can take a new point when empty, or when its current point drains now.
  assign free = (state == EMPTY) || ready_o;

  // Round-robin pick: a lone requester wins; on contention the one that did not
  // win last time goes. Suppressed during reset so nothing handshakes then.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = SRC_A;
    if (!rst && free) begin
      unique case (req)
        2'b01:   begin gnt_vld = 1'b1; gnt_id = SRC_A; end
        2'b10:   begin gnt_vld = 1'b1; gnt_id = SRC_B; end
        2'b11:   begin gnt_vld = 1'b1; gnt_id = (last == SRC_B) ? SRC_A : SRC_B; end
        default: begin gnt_vld = 1'b0; gnt_id = SRC_A; end
      endcase
    end
  end

  assign gnt_point = (gnt_id == SRC_B) ? point_i_B : point_i_A;
  assign ready_i_A = gnt_vld && (gnt_id == SRC_A);
  assign ready_i_B = gnt_vld && (gnt_id == SRC_B);

  // slot state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  // slot next state: a grant always fills; an unrefilled drain empties
  always_comb begin
    state_nx = state;
    if (gnt_vld)                          state_nx = FULL;
    else if ((state == FULL) && ready_o)  state_nx = EMPTY;
  end

  assign valid_o = (state == FULL);

  // capture the granted point, its source, and the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      point_o <= '0;
      src_o   <= SRC_A;
      last    <= SRC_B;
    end else if (gnt_vld) begin
      point_o <= gnt_point;
      src_o   <= gnt_id;
      last    <= gnt_id;
    end
  end

  // one saturating grant counter per source
  genvar s;
  generate
    for (s = 0; s < NUM_SRC; s++) begin : g_cnt
      assign inc[s] = gnt_vld && (gnt_id == s[0]);
      point_sat_cnt #(.COUNT_W(COUNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc[s]),
        .cnt (cnt[s])
      );
    end
  endgenerate

  assign cnt_A = cnt[0];
  assign cnt_B = cnt[1];

endmodule

// File: tb/tb_point_rr_arbiter.sv
// Bench for point_rr_arbiter: a transaction-level model checked every cycle,
// plus directed literal checks from the test plan. A second instance with a
// 2-bit counter width exercises saturation under the same stimulus.
module tb_point_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] point_i_A, point_i_B;
  logic        valid_i_A, valid_i_B, ready_o;

  logic        ready_i_A, ready_i_B, src_o, valid_o;
  logic [15:0] point_o;
  logic [15:0] cnt_A, cnt_B;

  logic        s_ready_i_A, s_ready_i_B, s_src_o, s_valid_o;
  logic [15:0] s_point_o;
  logic [1:0]  s_cnt_A, s_cnt_B;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  point_rr_arbiter #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .point_i_A(point_i_A), .valid_i_A(valid_i_A), .ready_i_A(ready_i_A),
    .point_i_B(point_i_B), .valid_i_B(valid_i_B), .ready_i_B(ready_i_B),
    .point_o(point_o), .src_o(src_o), .valid_o(valid_o), .ready_o(ready_o),
    .cnt_A(cnt_A), .cnt_B(cnt_B)
  );

  point_rr_arbiter #(.COUNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .point_i_A(point_i_A), .valid_i_A(valid_i_A), .ready_i_A(s_ready_i_A),
    .point_i_B(point_i_B), .valid_i_B(valid_i_B), .ready_i_B(s_ready_i_B),
    .point_o(s_point_o), .src_o(s_src_o), .valid_o(s_valid_o), .ready_o(ready_o),
    .cnt_A(s_cnt_A), .cnt_B(s_cnt_B)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_started = 0;
  bit          m_valid;
  logic [15:0] m_point;
  bit          m_src;
  bit          m_last;     // 1 = B
  int          m_nA, m_nB; // true grant totals since reset

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // who gets the slot this cycle: -1 none, 0 A, 1 B
  function automatic int pick();
    if (rst) return -1;
    if (m_valid && !ready_o) return -1;
    if (valid_i_A && valid_i_B) return m_last ? 0 : 1;
    if (valid_i_A) return 0;
    if (valid_i_B) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = pick();
    if (rst) begin
      m_started = 1; m_valid = 0; m_last = 1; m_nA = 0; m_nB = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_src   = (g == 1);
      m_point = (g == 1) ? point_i_B : point_i_A;
      m_last  = (g == 1);
      if (g == 1) m_nB++; else m_nA++;
    end else if (m_valid && ready_o) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    int g;
    if (m_started) begin
      g = pick();
      chk("m.valid_o", valid_o, m_valid);
      chk("m.s_valid_o", s_valid_o, m_valid);
      if (m_valid) begin
        chk("m.point_o", point_o, m_point);
        chk("m.src_o", src_o, m_src);
        chk("m.s_point_o", s_point_o, m_point);
        chk("m.s_src_o", s_src_o, m_src);
      end
      chk("m.ready_i_A", ready_i_A, g == 0);
      chk("m.ready_i_B", ready_i_B, g == 1);
      chk("m.s_ready_i_A", s_ready_i_A, g == 0);
      chk("m.s_ready_i_B", s_ready_i_B, g == 1);
      chk("m.cnt_A", cnt_A, sat(m_nA, 65535));
      chk("m.cnt_B", cnt_B, sat(m_nB, 65535));
      chk("m.s_cnt_A", s_cnt_A, sat(m_nA, 3));
      chk("m.s_cnt_B", s_cnt_B, sat(m_nB, 3));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [0:5] exp_src;
    int         exp_sat [5];
    exp_src = 6'b010101;
    exp_sat = '{1, 2, 3, 3, 3};

    rst = 1; valid_i_A = 0; valid_i_B = 0; ready_o = 0;
    point_i_A = '0; point_i_B = '0;
    repeat (4) step();
    chk("reset.valid_o", valid_o, 0);
    chk("reset.cnt_A", cnt_A, 0);
    chk("reset.ready_i_A", ready_i_A, 0);

    // single request from A
    rst = 0; valid_i_A = 1; point_i_A = 16'h1234; ready_o = 1; #1;
    chk("single.ready_i_A", ready_i_A, 1);
    chk("single.ready_i_B", ready_i_B, 0);
    step(); valid_i_A = 0; #1;
    chk("single.point_o", point_o, 16'h1234);
    chk("single.src_o", src_o, 0);
    chk("single.valid_o", valid_o, 1);
    chk("single.cnt_A", cnt_A, 1);
    chk("single.cnt_B", cnt_B, 0);

    // contention from a fresh reset: A,B,A,B,A,B
    rst = 1; step(); step(); rst = 0;
    valid_i_A = 1; point_i_A = 16'h0101;
    valid_i_B = 1; point_i_B = 16'hffff;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr.src_o", src_o, exp_src[i]);
      chk("rr.point_o", point_o, exp_src[i] ? 16'hffff : 16'h0101);
    end
    chk("rr.cnt_A", cnt_A, 3);
    chk("rr.cnt_B", cnt_B, 3);

    // backpressure: slot holds B's fefe while A waits
    valid_i_A = 0; point_i_B = 16'hfefe;
    step();
    valid_i_B = 0; valid_i_A = 1; point_i_A = 16'h0a0b; ready_o = 0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp.ready_i_A", ready_i_A, 0);
      step();
      chk("bp.point_o", point_o, 16'hfefe);
      chk("bp.src_o", src_o, 1);
      chk("bp.valid_o", valid_o, 1);
    end
    ready_o = 1; #1;
    chk("bp.release_ready_i_A", ready_i_A, 1);
    step(); valid_i_A = 0; #1;
    chk("bp.point_o_next", point_o, 16'h0a0b);
    chk("bp.src_o_next", src_o, 0);
    chk("bp.valid_o_next", valid_o, 1);

    // idle drain
    step();
    chk("drain.valid_o", valid_o, 0);
    chk("drain.cnt_A", cnt_A, 4);
    chk("drain.cnt_B", cnt_B, 4);

    // saturation on the 2-bit instance
    rst = 1; step(); rst = 0;
    valid_i_A = 1; point_i_A = 16'h5566;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat.s_cnt_A", s_cnt_A, exp_sat[i]);
      chk("sat.cnt_A", cnt_A, i + 1);
    end

    // reset mid-operation with a pending A point
    valid_i_A = 0; ready_o = 0;
    step();
    chk("midrst.valid_before", valid_o, 1);
    rst = 1; valid_i_A = 1; valid_i_B = 1; #1;
    chk("midrst.ready_i_A", ready_i_A, 0);
    chk("midrst.ready_i_B", ready_i_B, 0);
    step(); rst = 0; #1;
    chk("midrst.valid_o", valid_o, 0);
    chk("midrst.cnt_A", cnt_A, 0);
    chk("midrst.cnt_B", cnt_B, 0);
    ready_o = 1; #1;
    chk("midrst.first_A", ready_i_A, 1);
    step();
    chk("midrst.src_o", src_o, 0);
    valid_i_A = 0; valid_i_B = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
